i2s_audio_tx: RTL and testbench

- Serialises the 16-bit stereo output of the audio filter chain into a standard Philips I2S stream: bit clock, word-select and data.
- Sits directly downstream of the IIR filter. It captures `output_l`/`output_r` on the same `sample_ce` the filter uses to update them, and drives the external DAC pins.
- Generates its own bit clock from `clk` via an integer divider.
- Decouples the sample rate from the frame rate with a one-deep pending buffer, and flags underrun and overrun.

---
 rtl/i2s_audio_tx.sv | 148 ++++++++++++++
 tb/tb_i2s_audio_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - Philips I2S transmitter for 16-bit stereo samples
//
// Serialises left/right samples into an I2S frame of 32 bit-clocks.
// It divides clk down to a bit clock and holds one frame-deep pending buffer.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   sample_ce    one-clk strobe, captures input_l/input_r into the pending buffer
//   input_l/r    16-bit signed left/right samples
//   i2s_sclk     bit clock, period 2*CLK_DIV clk
//   i2s_lrclk    word select, 0 = left, 1 = right, leads the word by one bit
//   i2s_sdata    serial data, MSB first, changes on the falling sclk edge
//   frame_start  one-clk pulse when a new frame is loaded into the shifter
//   underrun     one-clk pulse: frame loaded with no new sample pending
//   overrun      one-clk pulse: sample overwrote a still-pending sample

module i2s_audio_tx #(
  parameter int CLK_DIV          = 4,
  parameter bit MUTE_ON_UNDERRUN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_ce,
  input  logic [15:0] input_l,
  input  logic [15:0] input_r,
  output logic        i2s_sclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sclk_q, sclk_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic [4:0]  slot_q, slot_d;
  logic        armed_q, armed_d;
  logic [31:0] shift_q, shift_d;
  logic        pending_valid_q, pending_valid_d;
  logic [15:0] pending_l_q, pending_l_d;
  logic [15:0] pending_r_q, pending_r_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;

  logic        div_tc;
  logic        fall;
  logic        load;
  logic [31:0] load_data;

  assign div_tc = (div_cnt_q == DIV_TC);
  assign fall   = div_tc & sclk_q;
  // Frame boundary: the falling edge that wraps the slot counter 31 -> 0.
  assign load   = fall & armed_q & (slot_q == 5'd31);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q       <= '0;
      sclk_q          <= 1'b0;
      lrclk_q         <= 1'b0;
      sdata_q         <= 1'b0;
      slot_q          <= 5'd31;
      armed_q         <= 1'b0;
      shift_q         <= '0;
      pending_valid_q <= 1'b0;
      pending_l_q     <= '0;
      pending_r_q     <= '0;
      frame_start_q   <= 1'b0;
      underrun_q      <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      sclk_q          <= sclk_d;
      lrclk_q         <= lrclk_d;
      sdata_q         <= sdata_d;
      slot_q          <= slot_d;
      armed_q         <= armed_d;
      shift_q         <= shift_d;
      pending_valid_q <= pending_valid_d;
      pending_l_q     <= pending_l_d;
      pending_r_q     <= pending_r_d;
      frame_start_q   <= frame_start_d;
      underrun_q      <= underrun_d;
      overrun_q       <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    div_cnt_d       = div_tc ? 8'd0 : div_cnt_q + 8'd1;
    sclk_d          = div_tc ? ~sclk_q : sclk_q;
    // The first falling edge after reset is a lead-in bit that only arms the
    // slot counter, so the first frame loads on the second falling edge.
    armed_d         = armed_q | fall;
    slot_d          = slot_q;
    shift_d         = shift_q;
    sdata_d         = sdata_q;
    lrclk_d         = lrclk_q;
    pending_valid_d = pending_valid_q;
    pending_l_d     = pending_l_q;
    pending_r_d     = pending_r_q;
    frame_start_d   = load;
    underrun_d      = load & ~pending_valid_q;
    overrun_d       = 1'b0;

    // On underrun the stale pending data is repeated unless muting is chosen.
    if (!pending_valid_q && MUTE_ON_UNDERRUN) begin
      load_data = 32'd0;
    end else begin
      load_data = {pending_l_q, pending_r_q};
    end

    if (fall && armed_q) begin
      slot_d  = slot_q + 5'd1;
      shift_d = load ? load_data : {shift_q[30:0], 1'b0};
      sdata_d = shift_d[31];
      // Word select flips one bit before the MSB of the next word.
      lrclk_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
    end

    if (load) begin
      pending_valid_d = 1'b0;
    end

    // A capture on the load cycle lands after the load consumed the old data.
    if (sample_ce) begin
      pending_l_d     = input_l;
      pending_r_d     = input_r;
      pending_valid_d = 1'b1;
      overrun_d       = pending_valid_q & ~load;
    end
  end

  // Outputs come straight from registers
  assign i2s_sclk    = sclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed self-checking bench for i2s_audio_tx

module tb_i2s_audio_tx;

  localparam int CLK_DIV = 2;
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_ce = 1'b0;
  logic [15:0] in_l = 16'h0;
  logic [15:0] in_r = 16'h0;

  logic sclk, lrclk, sdata, fs, ur, ovr;
  logic sclk_m, lrclk_m, sdata_m, fs_m, ur_m, ovr_m;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int last_used = 0;

  i2s_audio_tx #(.CLK_DIV(CLK_DIV), .MUTE_ON_UNDERRUN(1'b0)) dut (
    .clk(clk), .reset(reset), .sample_ce(sample_ce),
    .input_l(in_l), .input_r(in_r),
    .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .frame_start(fs), .underrun(ur), .overrun(ovr)
  );

  i2s_audio_tx #(.CLK_DIV(CLK_DIV), .MUTE_ON_UNDERRUN(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sample_ce(sample_ce),
    .input_l(in_l), .input_r(in_r),
    .i2s_sclk(sclk_m), .i2s_lrclk(lrclk_m), .i2s_sdata(sdata_m),
    .frame_start(fs_m), .underrun(ur_m), .overrun(ovr_m)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ovr === 1'b1) ovr_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (fs === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Starts right after a frame load; collects sdata/lrclk at 32 sclk rises.
  task automatic capture(output logic [31:0] d, output logic [31:0] dm,
                         output logic [31:0] lr, output int nrise,
                         output int bad_per, output int used);
    logic prev;
    int   last;
    d = '0; dm = '0; lr = '0; nrise = 0; bad_per = 0; used = 0;
    prev = sclk;
    last = -1;
    while (nrise < 32 && used < 200) begin
      tick();
      used++;
      if (sclk === 1'b1 && prev === 1'b0) begin
        d  = {d[30:0], sdata};
        dm = {dm[30:0], sdata_m};
        lr = {lr[30:0], lrclk};
        if (last >= 0 && (used - last) != 2 * CLK_DIV) bad_per++;
        last = used;
        nrise++;
      end
      prev = sclk;
    end
  endtask

  task automatic test_reset();
    int n, nr, bp, used;
    logic [31:0] d, dm, lr;
    reset = 1'b0; sample_ce = 1'b1; in_l = 16'h7FFF; in_r = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({sclk, lrclk, sdata, fs, ur, ovr, sdata_m} !== 7'b0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got %b want 0000000", i, {sclk, lrclk, sdata, fs, ur, ovr, sdata_m});
      end
    end
    sample_ce = 1'b0; reset = 1'b1;
    wait_frame(40, n);
    tests++;
    if (n !== 8) begin fails++; $display("FAIL startup_latency: got %0d want 8", n); end
    tests++;
    if (ur !== 1'b1) begin fails++; $display("FAIL startup_underrun: got %b want 1", ur); end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (nr !== 32) begin fails++; $display("FAIL startup_rises: got %0d want 32", nr); end
    tests++;
    if (d !== 32'h0 || dm !== 32'h0) begin
      fails++; $display("FAIL startup_zero_frame: got %h/%h want 0/0", d, dm);
    end
    tests++;
    if (lr !== LR_PATTERN) begin fails++; $display("FAIL startup_lrclk: got %h want %h", lr, LR_PATTERN); end
  endtask

  task automatic test_basic_frame();
    int n, nr, bp, used;
    logic [31:0] d, dm, lr;
    in_l = 16'hA5C3; in_r = 16'h8001; sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    wait_frame(10, n);
    tests++;
    if (n !== 1) begin fails++; $display("FAIL basic_load_time: got %0d want 1", n); end
    tests++;
    if (ur !== 1'b0 || ovr !== 1'b0) begin
      fails++; $display("FAIL basic_flags: got ur=%b ovr=%b want 0 0", ur, ovr);
    end
    capture(d, dm, lr, nr, bp, used);
    last_used = used;
    tests++;
    if (d !== 32'hA5C3_8001 || dm !== 32'hA5C3_8001) begin
      fails++; $display("FAIL basic_data: got %h/%h want a5c38001", d, dm);
    end
    tests++;
    if (lr !== LR_PATTERN) begin fails++; $display("FAIL basic_lrclk: got %h want %h", lr, LR_PATTERN); end
    tests++;
    if (bp !== 0 || nr !== 32) begin
      fails++; $display("FAIL basic_sclk_period: got bad=%0d rises=%0d want 0 32", bp, nr);
    end
  endtask

  task automatic test_underrun();
    int n, nr, bp, used;
    logic [31:0] d, dm, lr;
    wait_frame(10, n);
    tests++;
    if (last_used + n !== 128) begin
      fails++; $display("FAIL frame_length: got %0d want 128", last_used + n);
    end
    tests++;
    if (ur !== 1'b1 || ur_m !== 1'b1) begin
      fails++; $display("FAIL underrun_flag: got %b/%b want 1/1", ur, ur_m);
    end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (d !== 32'hA5C3_8001) begin fails++; $display("FAIL underrun_repeat: got %h want a5c38001", d); end
    tests++;
    if (dm !== 32'h0) begin fails++; $display("FAIL underrun_mute: got %h want 00000000", dm); end
  endtask

  task automatic test_overrun();
    int n, nr, bp, used, base;
    logic [31:0] d, dm, lr;
    wait_frame(10, n);
    tests++;
    if (n < 1) begin fails++; $display("FAIL overrun_frame_wait: got %0d want >0", n); end
    base = ovr_cnt;
    fork
      capture(d, dm, lr, nr, bp, used);
      begin
        repeat (5) tick();
        in_l = 16'h1111; in_r = 16'hAAAA; sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        tick();
        tick();
        in_l = 16'h2222; in_r = 16'hBBBB; sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
      end
    join
    tests++;
    if (ovr_cnt - base !== 1) begin
      fails++; $display("FAIL overrun_count: got %0d want 1", ovr_cnt - base);
    end
    wait_frame(10, n);
    tests++;
    if (ur !== 1'b0) begin fails++; $display("FAIL overrun_next_underrun: got %b want 0", ur); end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (d !== 32'h2222_BBBB || dm !== 32'h2222_BBBB) begin
      fails++; $display("FAIL overrun_data: got %h/%h want 2222bbbb", d, dm);
    end
  endtask

  task automatic test_back_to_back();
    int n, nr, bp, used, base;
    logic [31:0] d, dm, lr;
    base = ovr_cnt;
    // previous capture returns on the slot-31 rise; load falls two clk later
    in_l = 16'h1234; in_r = 16'h4321; sample_ce = 1'b1;
    tick();
    tests++;
    if (ovr !== 1'b0 || fs !== 1'b0) begin
      fails++; $display("FAIL simul_pre: got ovr=%b fs=%b want 0 0", ovr, fs);
    end
    in_l = 16'h5678; in_r = 16'h8765;
    tick();
    sample_ce = 1'b0;
    tests++;
    if ({fs, ur, ovr} !== 3'b100) begin
      fails++; $display("FAIL simul_load_flags: got fs/ur/ovr=%b want 100", {fs, ur, ovr});
    end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (d !== 32'h1234_4321) begin fails++; $display("FAIL simul_old_data: got %h want 12344321", d); end
    tests++;
    if (ovr_cnt !== base) begin fails++; $display("FAIL simul_no_overrun: got %0d want %0d", ovr_cnt, base); end
    wait_frame(10, n);
    tests++;
    if (n !== 2 || ur !== 1'b0) begin
      fails++; $display("FAIL simul_next_frame: got n=%0d ur=%b want 2 0", n, ur);
    end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (d !== 32'h5678_8765 || dm !== 32'h5678_8765) begin
      fails++; $display("FAIL simul_new_data: got %h/%h want 56788765", d, dm);
    end
  endtask

  task automatic test_reset_midframe();
    int n, nr, bp, used, rises, cnt;
    logic prev;
    logic [31:0] d, dm, lr;
    wait_frame(10, n);
    rises = 0; cnt = 0; prev = sclk;
    while (rises < 21 && cnt < 200) begin
      tick();
      cnt++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
    end
    tests++;
    if (lrclk !== 1'b1 || sclk !== 1'b1) begin
      fails++; $display("FAIL midframe_slot20: got lrclk=%b sclk=%b want 1 1", lrclk, sclk);
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({sclk, lrclk, sdata, fs, ur, ovr} !== 6'b0) begin
      fails++; $display("FAIL midframe_reset_outputs: got %b want 000000", {sclk, lrclk, sdata, fs, ur, ovr});
    end
    reset = 1'b1;
    wait_frame(40, n);
    tests++;
    if (n !== 8 || ur !== 1'b1) begin
      fails++; $display("FAIL midframe_restart: got n=%0d ur=%b want 8 1", n, ur);
    end
    capture(d, dm, lr, nr, bp, used);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL midframe_pending_cleared: got %h want 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
